shiftrows_feeder: RTL and testbench
===================================

// Module: shiftrows_feeder
// PURPOSE
//  AES ShiftRows stage directly upstream of the MixColumns engine. Accepts one 128-bit
//  state on a valid/ready handshake and performs ShiftRows one row per cycle. It then
//  drives the MixColumns start/statew interface and holds it stable until done. Finally
//  it captures the MixColumns result and presents it on a valid/ready output.
// PARAMETERS
//  INV         0   0 = ShiftRows (row r rotates left by r); 1 = InvShiftRows (right by r)
//  MC_TIMEOUT  64  max cycles in HOLD waiting for mc_done before abort; 0 = no timeout
// PORTS
//  clk           in   1   single clock, all state on posedge
//  rst_n         in   1   asynchronous, active-low reset
//  in_valid      in   1   upstream state word set valid
//  in_ready      out  1   block can accept (high only in IDLE)
//  in_w1..in_w4  in   32  state columns 0..3; bits[31:24]=row0 ... [7:0]=row3
//  mc_start      out  1   to MixColumns start; level, held high for whole pass
//  mc_w1..mc_w4  out  32  to MixColumns statew1..4 (shifted state)
//  mc_done       in   1   from MixColumns done (1-cycle pulse)
//  mc_r1..mc_r4  in   32  from MixColumns new_statew1..4
//  out_valid     out  1   result valid
//  out_ready     in   1   downstream accepts result
//  out_w1..out_w4 out 32  MixColumns result columns 0..3
//  err           out  1   sticky: MixColumns timeout occurred; cleared on next accept
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, mc_start=0, in_ready=0 during reset then 1,
//   out_valid=0, err=0, mc_w*/out_w*=0, row counter=0. mc_start drops immediately.
//  FSM: IDLE -> SHIFT -> HOLD -> RELEASE -> OUTPUT -> IDLE.
//  IDLE: in_ready=1. in_valid&in_ready at edge: latch in_w1..4, row=0, err=0, -> SHIFT.
//  SHIFT: 4 cycles, row=0..3. Each cycle writes row r byte of mc_w column c:
//   INV=0: mc_w[c].row r = in[(c+r)%4].row r; INV=1: in[(c-r)%4].row r (mod 4).
//   Row 0 still takes its cycle. After row=3 -> HOLD. The 2-bit row counter wraps to 0.
//  HOLD: mc_start=1, mc_w* frozen; cycle counter increments. On mc_done=1 -> RELEASE.
//   If MC_TIMEOUT!=0 and counter reaches MC_TIMEOUT without done: err=1, mc_start=0,
//   -> IDLE, no out_valid.
//  RELEASE: one cycle; mc_start=0 (resets MixColumns counter); capture mc_r1..4 into
//   out_w1..4. MixColumns writes its last byte on the done edge, so capture is one
//   cycle after done. -> OUTPUT.
//  OUTPUT: out_valid=1, out_w* stable until out_valid&out_ready at an edge -> IDLE.
//   out_ready may be held high; the result then drains after exactly 1 OUTPUT cycle.
//  mc_done outside HOLD is ignored. in_valid outside IDLE is ignored, because in_ready=0.
//  mc_start never goes 0->1 without at least one intervening low cycle
//   (RELEASE/IDLE/SHIFT guarantee this).
//  Latency, accept to out_valid: 4 (SHIFT) + HOLD duration to mc_done + 1 (RELEASE) + 1.
//  Throughput is one state per pass. No pipelining across passes.
//  Reset mid-operation: everything returns to reset values at once. No partial result
//   is ever presented.
// TESTING
//  1 FIPS-197 B rnd1: in d42711ae,e0bf98f1,b8b45de5,1e415230 -> mc_w
//    d4bf5d30,e0b452ae,b84111f1,1e2798e5; real MixColumns -> out 046681e5,e0cb199a,
//    48f8d37a,2806264c.
//  2 INV=1: feed d4bf5d30,e0b452ae,b84111f1,1e2798e5 -> mc_w d42711ae,e0bf98f1,
//    b8b45de5,1e415230.
//  3 Stub mc_done after 20 cycles; out_ready low 5 cycles -> out_valid held,
//    out_w stable, in_ready=0; release -> IDLE next cycle.
//  4 MC_TIMEOUT=8, mc_done never -> mc_start low after 8 HOLD cycles, err=1,
//    in_ready=1, out_valid=0; next accept clears err.
//  5 rst_n low during HOLD -> mc_start=0 same cycle, out_valid=0; clean pass after release.
//  6 Back-to-back: in_valid, out_ready tied high, 3 states -> mc_start has >=1 low cycle
//    between passes; 3 correct results in order.

Source files
------------

// File: rtl/shiftrows_feeder.sv
// AES ShiftRows (or InvShiftRows) feeder for a MixColumns engine: accepts a state, shifts
// one row per cycle, holds the MixColumns request until done, then presents the result.
module shiftrows_feeder #(
  parameter bit          INV        = 1'b0,
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_w1,
  input  logic [31:0] in_w2,
  input  logic [31:0] in_w3,
  input  logic [31:0] in_w4,
  output logic        mc_start,
  output logic [31:0] mc_w1,
  output logic [31:0] mc_w2,
  output logic [31:0] mc_w3,
  output logic [31:0] mc_w4,
  input  logic        mc_done,
  input  logic [31:0] mc_r1,
  input  logic [31:0] mc_r2,
  input  logic [31:0] mc_r3,
  input  logic [31:0] mc_r4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_w1,
  output logic [31:0] out_w2,
  output logic [31:0] out_w3,
  output logic [31:0] out_w4,
  output logic        err
);

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned CNT_W    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;

  // One column word: element [3] is row 0 (bits 31:24), element [0] is row 3.
  typedef logic [3:0][7:0] col_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    HOLD    = 3'd2,
    RELEASE = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  state_t            state_q, state_nxt;
  logic [1:0]        row_q, row_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  col_t [3:0]        in_q, in_nxt;
  col_t [3:0]        mc_q, mc_nxt;
  col_t [3:0]        out_q, out_nxt;
  logic              err_q, err_nxt;
  logic              in_ready_q, mc_start_q, out_valid_q;

  // Source column for a byte landing in column c of row r.
  function automatic logic [1:0] src_col(input logic [1:0] c, input logic [1:0] r);
    return INV ? (c - r) : (c + r);
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      cnt_q       <= '0;
      in_q        <= '0;
      mc_q        <= '0;
      out_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      mc_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      row_q       <= row_nxt;
      cnt_q       <= cnt_nxt;
      in_q        <= in_nxt;
      mc_q        <= mc_nxt;
      out_q       <= out_nxt;
      err_q       <= err_nxt;
      in_ready_q  <= (state_nxt == IDLE);
      mc_start_q  <= (state_nxt == HOLD);
      out_valid_q <= (state_nxt == OUTPUT);
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_nxt = state_q;
    row_nxt   = row_q;
    cnt_nxt   = '0;
    in_nxt    = in_q;
    mc_nxt    = mc_q;
    out_nxt   = out_q;
    err_nxt   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          in_nxt    = {in_w4, in_w3, in_w2, in_w1};
          row_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        for (int c = 0; c < int'(NUM_COLS); c++) begin
          mc_nxt[2'(c)][~row_q] = in_q[src_col(2'(c), row_q)][~row_q];
        end
        row_nxt = row_q + 2'd1;
        if (row_q == 2'd3) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        cnt_nxt = cnt_q + CNT_W'(1);
        if (mc_done) begin
          state_nxt = RELEASE;
        end else if ((MC_TIMEOUT != 0) && (cnt_q == CNT_W'(MC_TIMEOUT - 1))) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RELEASE: begin
        // MixColumns finishes writing on the done edge, so its result is stable here.
        out_nxt   = {mc_r4, mc_r3, mc_r2, mc_r1};
        state_nxt = OUTPUT;
      end
      OUTPUT: begin
        if (out_valid_q && out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign mc_start  = mc_start_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign mc_w1     = mc_q[0];
  assign mc_w2     = mc_q[1];
  assign mc_w3     = mc_q[2];
  assign mc_w4     = mc_q[3];
  assign out_w1    = out_q[0];
  assign out_w2    = out_q[1];
  assign out_w3    = out_q[2];
  assign out_w4    = out_q[3];

endmodule

// File: tb/tb_shiftrows_feeder.sv
// Bench for shiftrows_feeder: two instances (ShiftRows / InvShiftRows with short timeout)
// driven by a MixColumns responder and checked against a byte-level AES reference.
module tb_shiftrows_feeder;

  int n_cmp = 0;
  int n_bad = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_w1 = '0, in_w2 = '0, in_w3 = '0, in_w4 = '0;
  logic        mc_done = 1'b0;
  logic [31:0] mc_r1 = '0, mc_r2 = '0, mc_r3 = '0, mc_r4 = '0;
  logic        out_ready = 1'b0;

  logic sel = 1'b0;
  int   done_delay = 3;
  bit   done_en = 1'b1;
  int   hcnt = 0;

  logic             rdy0, rdy1, st0, st1, ov0, ov1, er0, er1;
  logic [3:0][31:0] mcw0, mcw1, ow0, ow1;

  logic         in_ready_s, mc_start_s, out_valid_s, err_s;
  logic [127:0] mcw_s, outw_s;
  assign in_ready_s  = sel ? rdy1 : rdy0;
  assign mc_start_s  = sel ? st1 : st0;
  assign out_valid_s = sel ? ov1 : ov0;
  assign err_s       = sel ? er1 : er0;
  assign mcw_s  = sel ? {mcw1[0], mcw1[1], mcw1[2], mcw1[3]} : {mcw0[0], mcw0[1], mcw0[2], mcw0[3]};
  assign outw_s = sel ? {ow1[0], ow1[1], ow1[2], ow1[3]} : {ow0[0], ow0[1], ow0[2], ow0[3]};

  shiftrows_feeder #(.INV(1'b0), .MC_TIMEOUT(64)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_w1(in_w1), .in_w2(in_w2), .in_w3(in_w3), .in_w4(in_w4),
    .mc_start(st0), .mc_w1(mcw0[0]), .mc_w2(mcw0[1]), .mc_w3(mcw0[2]), .mc_w4(mcw0[3]),
    .mc_done(mc_done), .mc_r1(mc_r1), .mc_r2(mc_r2), .mc_r3(mc_r3), .mc_r4(mc_r4),
    .out_valid(ov0), .out_ready(out_ready),
    .out_w1(ow0[0]), .out_w2(ow0[1]), .out_w3(ow0[2]), .out_w4(ow0[3]), .err(er0));

  shiftrows_feeder #(.INV(1'b1), .MC_TIMEOUT(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_w1(in_w1), .in_w2(in_w2), .in_w3(in_w3), .in_w4(in_w4),
    .mc_start(st1), .mc_w1(mcw1[0]), .mc_w2(mcw1[1]), .mc_w3(mcw1[2]), .mc_w4(mcw1[3]),
    .mc_done(mc_done), .mc_r1(mc_r1), .mc_r2(mc_r2), .mc_r3(mc_r3), .mc_r4(mc_r4),
    .out_valid(ov1), .out_ready(out_ready),
    .out_w1(ow1[0]), .out_w2(ow1[1]), .out_w3(ow1[2]), .out_w4(ow1[3]), .err(er1));

  // AES reference: state as 128 bits, column 0 on top, row 0 the top byte of each column.
  function automatic logic [7:0] gb(input logic [127:0] s, input int c, input int r);
    return s[127-32*c-8*r -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = gb(s, inv ? (c - r + 4) % 4 : (c + r) % 4, r);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, c, 0); a1 = gb(s, c, 1); a2 = gb(s, c, 2); a3 = gb(s, c, 3);
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  // MixColumns responder: done pulses after done_delay cycles of start; result from statew.
  always @(negedge clk) begin
    if (mc_start_s) begin
      hcnt = hcnt + 1;
      mc_done = done_en && (hcnt == done_delay);
    end else begin
      hcnt = 0;
      mc_done = 1'b0;
    end
    {mc_r1, mc_r2, mc_r3, mc_r4} = mix_columns(mcw_s);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [127:0] s, output bit ok);
    ok = 1'b0;
    {in_w1, in_w2, in_w3, in_w4} = s;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready_s) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid_s) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mc_start_s) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b%b exp=00", rdy0, rdy1); end
    n_cmp++; if (st0 !== 1'b0 || ov0 !== 1'b0 || er0 !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl start/valid/err got=%b%b%b exp=000", st0, ov0, er0); end
    n_cmp++; if (mcw0 !== '0 || ow0 !== '0) begin n_bad++; $display("FAIL reset_data mc_w=%h out_w=%h exp=0", mcw0, ow0); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready got=%b%b exp=11", rdy0, rdy1); end
  endtask

  task automatic test_fips();
    logic [127:0] s;
    logic [3:0] st;
    bit ok;
    s = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    sel = 1'b0; do_reset();
    out_ready = 1'b1; done_en = 1'b1; done_delay = 3;
    send(s, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL fips_accept got=timeout exp=accept"); end
    n_cmp++; if (in_ready_s !== 1'b0) begin n_bad++; $display("FAIL fips_busy_ready got=%b exp=0", in_ready_s); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      st[k] = mc_start_s;
    end
    n_cmp++; if (st !== 4'b1000) begin n_bad++; $display("FAIL fips_shift_cycles start_trace=%b exp=1000", st); end
    n_cmp++; if (mcw_s !== 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5) begin n_bad++; $display("FAIL fips_mc_w got=%h exp=d4bf5d30e0b452aeb84111f11e2798e5", mcw_s); end
    wait_out(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL fips_out_valid got=timeout exp=valid"); end
    n_cmp++; if (outw_s !== 128'h046681e5_e0cb199a_48f8d37a_2806264c) begin n_bad++; $display("FAIL fips_out_w got=%h exp=046681e5e0cb199a48f8d37a2806264c", outw_s); end
    @(negedge clk);
    n_cmp++; if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin n_bad++; $display("FAIL fips_drain valid/ready got=%b%b exp=01", out_valid_s, in_ready_s); end
  endtask

  task automatic test_inv();
    logic [127:0] s;
    bit ok;
    s = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    sel = 1'b1; do_reset();
    out_ready = 1'b1; done_en = 1'b1; done_delay = 2;
    send(s, ok);
    wait_start(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL inv_start got=timeout exp=start"); end
    n_cmp++; if (mcw_s !== 128'hd42711ae_e0bf98f1_b8b45de5_1e415230) begin n_bad++; $display("FAIL inv_mc_w got=%h exp=d42711aee0bf98f1b8b45de51e415230", mcw_s); end
    wait_out(ok);
    n_cmp++; if (outw_s !== mix_columns(shift_rows(s, 1'b1)) || err_s !== 1'b0) begin n_bad++; $display("FAIL inv_out got=%h err=%b exp=%h err=0", outw_s, err_s, mix_columns(shift_rows(s, 1'b1))); end
  endtask

  task automatic test_random();
    logic [127:0] s;
    bit ok;
    for (int v = 0; v < 2; v++) begin
      sel = v[0]; do_reset();
      out_ready = 1'b1; done_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
        s = {$urandom, $urandom, $urandom, $urandom};
        done_delay = int'($urandom_range(1, 6));
        send(s, ok);
        wait_start(ok);
        n_cmp++; if (mcw_s !== shift_rows(s, sel)) begin n_bad++; $display("FAIL rand_mc_w inv=%0d got=%h exp=%h", sel, mcw_s, shift_rows(s, sel)); end
        wait_out(ok);
        n_cmp++; if (!ok || outw_s !== mix_columns(shift_rows(s, sel))) begin n_bad++; $display("FAIL rand_out inv=%0d got=%h exp=%h", sel, outw_s, mix_columns(shift_rows(s, sel))); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] s, e;
    bit ok;
    sel = 1'b0; do_reset();
    out_ready = 1'b0; done_en = 1'b1; done_delay = 20;
    s = {$urandom, $urandom, $urandom, $urandom};
    e = mix_columns(shift_rows(s, 1'b0));
    send(s, ok);
    wait_out(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_out_valid got=timeout exp=valid"); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (out_valid_s !== 1'b1 || outw_s !== e || in_ready_s !== 1'b0) begin n_bad++; $display("FAIL bp_hold cyc=%0d valid=%b ready=%b out=%h exp valid=1 ready=0 out=%h", k, out_valid_s, in_ready_s, outw_s, e); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin n_bad++; $display("FAIL bp_release valid/ready got=%b%b exp=01", out_valid_s, in_ready_s); end
  endtask

  task automatic test_timeout();
    logic [127:0] s;
    bit ok;
    int n;
    sel = 1'b1; do_reset();
    out_ready = 1'b1; done_en = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, ok);
    wait_start(ok);
    n = 0;
    while (mc_start_s === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    n_cmp++; if (n != 8) begin n_bad++; $display("FAIL to_hold_cycles got=%0d exp=8", n); end
    n_cmp++; if (err_s !== 1'b1 || in_ready_s !== 1'b1 || out_valid_s !== 1'b0) begin n_bad++; $display("FAIL to_flags err/ready/valid got=%b%b%b exp=110", err_s, in_ready_s, out_valid_s); end
    done_en = 1'b1; done_delay = 2;
    s = {$urandom, $urandom, $urandom, $urandom};
    send(s, ok);
    n_cmp++; if (err_s !== 1'b0) begin n_bad++; $display("FAIL to_err_clear got=%b exp=0", err_s); end
    wait_out(ok);
    n_cmp++; if (!ok || outw_s !== mix_columns(shift_rows(s, 1'b1))) begin n_bad++; $display("FAIL to_next_out got=%h exp=%h", outw_s, mix_columns(shift_rows(s, 1'b1))); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] s;
    bit ok;
    sel = 1'b0; do_reset();
    out_ready = 1'b1; done_en = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, ok);
    wait_start(ok);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mc_start_s !== 1'b0 || out_valid_s !== 1'b0 || in_ready_s !== 1'b0) begin n_bad++; $display("FAIL rstmid start/valid/ready got=%b%b%b exp=000", mc_start_s, out_valid_s, in_ready_s); end
    n_cmp++; if (mcw_s !== '0) begin n_bad++; $display("FAIL rstmid_mc_w got=%h exp=0", mcw_s); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    done_en = 1'b1; done_delay = 4;
    s = {$urandom, $urandom, $urandom, $urandom};
    send(s, ok);
    wait_out(ok);
    n_cmp++; if (!ok || outw_s !== mix_columns(shift_rows(s, 1'b0))) begin n_bad++; $display("FAIL rstmid_clean_pass got=%h exp=%h", outw_s, mix_columns(shift_rows(s, 1'b0))); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d [3];
    int idx, rx, passes, low_run;
    logic prev;
    sel = 1'b0; do_reset();
    out_ready = 1'b1; done_en = 1'b1; done_delay = int'($urandom_range(1, 4));
    for (int i = 0; i < 3; i++) d[i] = {$urandom, $urandom, $urandom, $urandom};
    idx = 0; rx = 0; passes = 0; low_run = 0; prev = 1'b0;
    for (int cyc = 0; cyc < 300 && rx < 3; cyc++) begin
      @(negedge clk);
      if (idx < 3) begin
        in_valid = 1'b1;
        {in_w1, in_w2, in_w3, in_w4} = d[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready_s) idx++;
      if (mc_start_s && !prev) begin
        if (passes > 0) begin
          n_cmp++; if (low_run < 1) begin n_bad++; $display("FAIL b2b_start_gap pass=%0d low_cycles=%0d exp>=1", passes, low_run); end
        end
        passes++;
        low_run = 0;
      end
      if (!mc_start_s) low_run++;
      prev = mc_start_s;
      if (out_valid_s) begin
        n_cmp++; if (outw_s !== mix_columns(shift_rows(d[rx], 1'b0))) begin n_bad++; $display("FAIL b2b_out idx=%0d got=%h exp=%h", rx, outw_s, mix_columns(shift_rows(d[rx], 1'b0))); end
        rx++;
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (rx != 3) begin n_bad++; $display("FAIL b2b_count got=%0d exp=3", rx); end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_inv();
    test_random();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim_time=%0t exp=finish before limit", $time);
    $fatal(1, "watchdog");
  end

endmodule
